// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep fault manager and comparator variants.
package lockstep_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        SUSPECT = 2'd1,
        RECOVER = 2'd2,
        FAILED  = 2'd3
    } lsfm_state_e;

    localparam int unsigned MISMATCH_TOTAL_W = 16;

    typedef enum logic [1:0] {
        SMP_IDLE = 2'd0,
        SMP_GOOD = 2'd1,
        SMP_BAD  = 2'd2
    } sample_e;

    // Inconsistent flag pairs (both set or both clear) count as bad: fail-safe.
    function automatic sample_e classify_sample(input logic en, input logic match,
                                                input logic mismatch);
        if (!en) begin
            return SMP_IDLE;
        end
        if (match && !mismatch) begin
            return SMP_GOOD;
        end
        return SMP_BAD;
    endfunction

endpackage

// File: rtl/lockstep_fault_manager_hold_timer.sv
// Loadable down-counter that times the core stall during a recovery.
module hold_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lockstep_fault_manager.sv
// Filters comparator mismatches, runs checkpoint recoveries and escalates to a
// sticky FAILED state after too many retries.
module lockstep_fault_manager
    import lockstep_pkg::*;
#(
    parameter int unsigned MISMATCH_THRESHOLD = 3,
    parameter int unsigned RECOVERY_CYCLES    = 16,
    parameter int unsigned MAX_RETRIES        = 2,
    parameter int unsigned CLEAN_WINDOW       = 256
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               compare_en,
    input  logic                               match,
    input  logic                               mismatch,
    input  logic                               fault_ack,
    output logic                               core_hold,
    output logic                               core_restart,
    output logic                               fault_irq,
    output logic [1:0]                         state,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [MISMATCH_TOTAL_W-1:0]        mismatch_total
);

    localparam int unsigned CONSEC_W = $clog2(MISMATCH_THRESHOLD + 1);
    localparam int unsigned RETRY_W  = $clog2(MAX_RETRIES + 1);
    localparam int unsigned CLEAN_W  = $clog2(CLEAN_WINDOW + 1);
    localparam int unsigned TIMER_W  = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;

    localparam logic [CONSEC_W-1:0] THRESH      = CONSEC_W'(MISMATCH_THRESHOLD);
    localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    localparam logic [CLEAN_W-1:0]  CLEAN_LIMIT = CLEAN_W'(CLEAN_WINDOW);
    localparam logic [TIMER_W-1:0]  HOLD_LOAD   = TIMER_W'(RECOVERY_CYCLES - 1);

    lsfm_state_e                 state_q;
    logic [CONSEC_W-1:0]         consec_q;
    logic [CLEAN_W-1:0]          clean_q;
    logic [RETRY_W-1:0]          retry_q;
    logic [MISMATCH_TOTAL_W-1:0] total_q;
    logic                        hold_q;
    logic                        restart_q;
    logic                        irq_q;

    sample_e                     sample;
    logic [CONSEC_W-1:0]         consec_d;
    logic [CLEAN_W-1:0]          clean_d;
    logic [MISMATCH_TOTAL_W-1:0] total_d;
    logic                        confirm;
    logic                        to_recover;
    logic                        timer_en;
    logic                        timer_zero;

    // Sample classification and the confirm decision shared by MONITOR and SUSPECT.
    // consec_q is always 0 in MONITOR, so consec_d == THRESH also covers THRESHOLD=1.
    always_comb begin
        sample     = classify_sample(compare_en, match, mismatch);
        consec_d   = consec_q + 1'b1;
        clean_d    = clean_q + 1'b1;
        total_d    = (total_q != '1) ? total_q + 1'b1 : total_q;
        confirm    = (sample == SMP_BAD) && (consec_d == THRESH) &&
                     ((state_q == MONITOR) || (state_q == SUSPECT));
        to_recover = confirm && (retry_q != RETRY_LIMIT);
        timer_en   = (state_q == RECOVER);
    end

    hold_timer #(
        .WIDTH (TIMER_W)
    ) u_hold_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (to_recover),
        .load_val_i (HOLD_LOAD),
        .en_i       (timer_en),
        .zero_o     (timer_zero)
    );

    // Main FSM with counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MONITOR;
            consec_q  <= '0;
            clean_q   <= '0;
            retry_q   <= '0;
            total_q   <= '0;
            hold_q    <= 1'b0;
            restart_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            restart_q <= 1'b0;
            case (state_q)
                MONITOR: begin
                    case (sample)
                        SMP_BAD: begin
                            consec_q <= consec_d;
                            total_q  <= total_d;
                            clean_q  <= '0;
                            state_q  <= SUSPECT;
                        end
                        SMP_GOOD: begin
                            if (clean_d == CLEAN_LIMIT) begin
                                retry_q <= '0;
                                clean_q <= '0;
                            end else begin
                                clean_q <= clean_d;
                            end
                        end
                        default: ;
                    endcase
                end
                SUSPECT: begin
                    case (sample)
                        SMP_BAD: begin
                            consec_q <= consec_d;
                            total_q  <= total_d;
                        end
                        SMP_GOOD: begin
                            consec_q <= '0;
                            clean_q  <= '0;
                            state_q  <= MONITOR;
                        end
                        default: ;
                    endcase
                end
                RECOVER: begin
                    if (timer_zero) begin
                        state_q  <= MONITOR;
                        hold_q   <= 1'b0;
                        consec_q <= '0;
                        clean_q  <= '0;
                    end
                end
                FAILED: begin
                    if (fault_ack) begin
                        state_q  <= MONITOR;
                        hold_q   <= 1'b0;
                        irq_q    <= 1'b0;
                        retry_q  <= '0;
                        consec_q <= '0;
                        clean_q  <= '0;
                    end
                end
            endcase
            // Recovery entry overrides the per-state next state chosen above.
            if (confirm) begin
                hold_q <= 1'b1;
                if (to_recover) begin
                    state_q   <= RECOVER;
                    retry_q   <= retry_q + 1'b1;
                    restart_q <= 1'b1;
                end else begin
                    state_q <= FAILED;
                    irq_q   <= 1'b1;
                end
            end
        end
    end

    assign state          = state_q;
    assign core_hold      = hold_q;
    assign core_restart   = restart_q;
    assign fault_irq      = irq_q;
    assign retry_count    = retry_q;
    assign mismatch_total = total_q;

endmodule

// File: tb/tb_lockstep_fault_manager.sv
// Table-driven scoreboard bench for lockstep_fault_manager.
module tb_lockstep_fault_manager;

    localparam logic [1:0] SM = 2'd0, SS = 2'd1, SR = 2'd2, SF = 2'd3;

    // stimulus encoding {compare_en, match, mismatch, fault_ack}
    localparam logic [3:0] BAD  = 4'b1010;
    localparam logic [3:0] GOOD = 4'b1100;
    localparam logic [3:0] I11  = 4'b1110;
    localparam logic [3:0] I00  = 4'b1000;
    localparam logic [3:0] OFF  = 4'b0000;
    localparam logic [3:0] OFFB = 4'b0010;
    localparam logic [3:0] OFFG = 4'b0100;
    localparam logic [3:0] ACK  = 4'b0001;
    localparam logic [3:0] GACK = 4'b1101;

    typedef struct {
        logic [3:0]  stim;
        logic [1:0]  st;
        logic        hold;
        logic        rst;
        logic        irq;
        logic [1:0]  ret;
        logic [15:0] tot;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        compare_en = 1'b0, match = 1'b0, mismatch = 1'b0, fault_ack = 1'b0;
    logic        core_hold, core_restart, fault_irq;
    logic [1:0]  state;
    logic [1:0]  retry_count;
    logic [15:0] mismatch_total;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    vec_t        tbl[$];
    vec_t        exp_q[$];

    lockstep_fault_manager #(
        .MISMATCH_THRESHOLD (3),
        .RECOVERY_CYCLES    (4),
        .MAX_RETRIES        (2),
        .CLEAN_WINDOW       (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .compare_en     (compare_en),
        .match          (match),
        .mismatch       (mismatch),
        .fault_ack      (fault_ack),
        .core_hold      (core_hold),
        .core_restart   (core_restart),
        .fault_irq      (fault_irq),
        .state          (state),
        .retry_count    (retry_count),
        .mismatch_total (mismatch_total)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [3:0] stim, input logic [1:0] st, input logic h,
                               input logic r, input logic i, input logic [1:0] ret,
                               input logic [15:0] tot);
        vec_t x;
        x.stim = stim; x.st = st; x.hold = h; x.rst = r; x.irq = i; x.ret = ret; x.tot = tot;
        return x;
    endfunction

    task automatic check_vec(input string name, input int idx);
        vec_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s #%0d: scoreboard empty, got output with no expectation", name, idx);
            return;
        end
        e = exp_q.pop_front();
        if ({state, core_hold, core_restart, fault_irq, retry_count, mismatch_total} !==
            {e.st, e.hold, e.rst, e.irq, e.ret, e.tot}) begin
            n_miss++;
            $display("FAIL %s #%0d: got st=%0d hold=%b rst=%b irq=%b ret=%0d tot=%0d, expected st=%0d hold=%b rst=%b irq=%b ret=%0d tot=%0d",
                     name, idx, state, core_hold, core_restart, fault_irq, retry_count,
                     mismatch_total, e.st, e.hold, e.rst, e.irq, e.ret, e.tot);
        end
    endtask

    task automatic apply(input vec_t x, input string name, input int idx);
        {compare_en, match, mismatch, fault_ack} = x.stim;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        check_vec(name, idx);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) apply(tbl[i], name, i);
        tbl.delete();
    endtask

    task automatic do_reset(input string name);
        {compare_en, match, mismatch, fault_ack} = OFF;
        reset = 1'b0;
        #1;
        exp_q.push_back(v(OFF, SM, 0, 0, 0, 2'd0, 16'd0));
        check_vec(name, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected summary before 100us");
        $fatal(1);
    end

    initial begin
        #2;
        // Transient mismatch
        do_reset("reset_a");
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 0, 1));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 0, 2));
        tbl.push_back(v(GOOD, SM, 0, 0, 0, 0, 2));
        tbl.push_back(v(GOOD, SM, 0, 0, 0, 0, 2));
        run_table("transient");

        // Confirmed fault, exact clean window, clean window broken by a bad sample
        do_reset("reset_b");
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 0, 1));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 0, 2));
        tbl.push_back(v(BAD,  SR, 1, 1, 0, 1, 3));
        tbl.push_back(v(BAD,  SR, 1, 0, 0, 1, 3));
        tbl.push_back(v(BAD,  SR, 1, 0, 0, 1, 3));
        tbl.push_back(v(I11,  SR, 1, 0, 0, 1, 3));
        tbl.push_back(v(BAD,  SM, 0, 0, 0, 1, 3));
        for (int i = 0; i < 7; i++) tbl.push_back(v(GOOD, SM, 0, 0, 0, 1, 3));
        tbl.push_back(v(GOOD, SM, 0, 0, 0, 0, 3));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 0, 4));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 0, 5));
        tbl.push_back(v(BAD,  SR, 1, 1, 0, 1, 6));
        for (int i = 0; i < 3; i++) tbl.push_back(v(GOOD, SR, 1, 0, 0, 1, 6));
        tbl.push_back(v(GOOD, SM, 0, 0, 0, 1, 6));
        for (int i = 0; i < 7; i++) tbl.push_back(v(GOOD, SM, 0, 0, 0, 1, 6));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 1, 7));
        for (int i = 0; i < 7; i++) tbl.push_back(v(GOOD, SM, 0, 0, 0, 1, 7));
        tbl.push_back(v(GOOD, SM, 0, 0, 0, 1, 7));
        tbl.push_back(v(GOOD, SM, 0, 0, 0, 0, 7));
        run_table("fault_clean");

        // Inconsistent / disabled samples, second recovery, escalation to FAILED
        do_reset("reset_d");
        tbl.push_back(v(I11,  SS, 0, 0, 0, 0, 1));
        tbl.push_back(v(I00,  SS, 0, 0, 0, 0, 2));
        tbl.push_back(v(I11,  SR, 1, 1, 0, 1, 3));
        for (int i = 0; i < 3; i++) tbl.push_back(v(OFF, SR, 1, 0, 0, 1, 3));
        tbl.push_back(v(OFF,  SM, 0, 0, 0, 1, 3));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 1, 4));
        tbl.push_back(v(OFFB, SS, 0, 0, 0, 1, 4));
        tbl.push_back(v(OFFG, SS, 0, 0, 0, 1, 4));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 1, 5));
        tbl.push_back(v(OFF,  SS, 0, 0, 0, 1, 5));
        tbl.push_back(v(BAD,  SR, 1, 1, 0, 2, 6));
        for (int i = 0; i < 3; i++) tbl.push_back(v(BAD, SR, 1, 0, 0, 2, 6));
        tbl.push_back(v(BAD,  SM, 0, 0, 0, 2, 6));
        tbl.push_back(v(OFFB, SM, 0, 0, 0, 2, 6));
        tbl.push_back(v(GACK, SM, 0, 0, 0, 2, 6));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 2, 7));
        tbl.push_back(v(BAD,  SS, 0, 0, 0, 2, 8));
        tbl.push_back(v(BAD,  SF, 1, 0, 1, 2, 9));
        run_table("escalate");
        for (int i = 0; i < 50; i++) begin
            logic [3:0] s;
            s = 4'($urandom()) & 4'b1110;
            apply(v(s, SF, 1, 0, 1, 2, 9), "failed_hold", i);
        end
        apply(v(ACK,  SM, 0, 0, 0, 0, 9), "failed_ack", 0);
        apply(v(GACK, SM, 0, 0, 0, 0, 9), "ack_in_monitor", 0);

        // Reset in the second RECOVER cycle drops outputs asynchronously
        do_reset("reset_e");
        tbl.push_back(v(BAD, SS, 0, 0, 0, 0, 1));
        tbl.push_back(v(BAD, SS, 0, 0, 0, 0, 2));
        tbl.push_back(v(BAD, SR, 1, 1, 0, 1, 3));
        tbl.push_back(v(BAD, SR, 1, 0, 0, 1, 3));
        run_table("pre_reset");
        reset = 1'b0;
        #1;
        exp_q.push_back(v(OFF, SM, 0, 0, 0, 0, 0));
        check_vec("reset_mid_recover", 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply(v(BAD, SS, 0, 0, 0, 0, 1), "after_reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
